// File: rtl/sti_pkg.sv
// Shared definitions for the share-collection (unmasking) end of the TI S-box datapath.
// Defaults here are also used by the share-function blocks upstream.
package sti_pkg;

  localparam int STI_IDX_W   = 3;
  localparam int STI_WIDTH   = 4;
  localparam int STI_NSHARES = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } sti_state_e;

endpackage

// File: rtl/sti_share_collector.sv
// Collects TI S-box output shares in index order, XOR-recombines them and presents the
// plaintext nibble on a valid/ready port. Partial sums never leave the block.
module sti_share_collector
  import sti_pkg::*;
#(
  parameter int WIDTH   = STI_WIDTH,
  parameter int NSHARES = STI_NSHARES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_share,
  input  logic [STI_IDX_W-1:0] s_idx,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 err
);

  localparam logic [STI_IDX_W-1:0] LAST_IDX = STI_IDX_W'(NSHARES - 1);

  sti_state_e           state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [STI_IDX_W-1:0] cnt_q, cnt_d;
  logic                 rdy_q, rdy_d;
  logic                 err_q, err_d;
  logic                 beat;

  // Outputs decode registers only; no input reaches an output combinationally.
  assign s_ready = rdy_q & (state_q != OUT);
  assign m_valid = (state_q == OUT);
  assign m_data  = (state_q == OUT) ? acc_q : '0;
  assign err     = err_q;

  assign beat = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b1;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          if (s_idx == '0) begin
            acc_d   = s_share;
            cnt_d   = STI_IDX_W'(1);
            state_d = ACC;
          end else begin
            err_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end
        end
      end
      ACC: begin
        if (beat) begin
          if (s_idx == cnt_q) begin
            acc_d = acc_q ^ s_share;
            cnt_d = cnt_q + STI_IDX_W'(1);
            if (s_idx == LAST_IDX) begin
              state_d = OUT;
            end
          end else begin
            // Out-of-order beat: the partial sum is always discarded.
            err_d = 1'b1;
            if (s_idx == '0) begin
              acc_d = s_share;
              cnt_d = STI_IDX_W'(1);
            end else begin
              acc_d   = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end
      OUT: begin
        if (m_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sti_share_collector.sv
// Directed bench for sti_share_collector: per-cycle vector table plus reset and
// random-legal-traffic sequences.
module tb_sti_share_collector;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_share;
  logic [2:0] s_idx;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic       err;

  int n_tests;
  int n_fail;
  bit mon_en;

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic [3:0] sh;
    logic       mr;
    logic       e_sr;
    logic       e_mv;
    logic [3:0] e_md;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  sti_share_collector #(.WIDTH(4), .NSHARES(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_share (s_share),
    .s_idx   (s_idx),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] idx, input logic [3:0] sh, input logic mr);
    s_valid = v;
    s_idx   = idx;
    s_share = sh;
    m_ready = mr;
  endtask

  task automatic add(input logic v, input logic [2:0] idx, input logic [3:0] sh, input logic mr,
                     input logic e_sr, input logic e_mv, input logic [3:0] e_md, input logic e_err);
    vec_t r;
    r.v = v; r.idx = idx; r.sh = sh; r.mr = mr;
    r.e_sr = e_sr; r.e_mv = e_mv; r.e_md = e_md; r.e_err = e_err;
    vecs.push_back(r);
  endtask

  // m_data must read 0 in every cycle without m_valid.
  always @(negedge clk) begin
    if (mon_en && !m_valid) check("mdata_idle", 32'(m_data), 32'd0);
  end

  initial begin
    logic [3:0] exp_x;
    logic [3:0] sh;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    drive(1'b0, 3'd0, 4'h0, 1'b0);

    // back-to-back clean set, m_ready high
    add(1, 3'd0, 4'hA, 1, 1, 0, 4'h0, 0);
    add(1, 3'd1, 4'h6, 1, 1, 0, 4'h0, 0);
    add(1, 3'd2, 4'h3, 1, 1, 0, 4'h0, 0);
    add(0, 3'd0, 4'h0, 1, 0, 1, 4'hF, 0);
    add(0, 3'd0, 4'h0, 1, 1, 0, 4'h0, 0);
    // back-to-back errors in IDLE give consecutive pulses
    add(1, 3'd1, 4'h5, 0, 1, 0, 4'h0, 0);
    add(1, 3'd2, 4'h5, 0, 1, 0, 4'h0, 1);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 1);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 0);
    // gapped set, output back-pressured for 5 cycles
    add(1, 3'd0, 4'hA, 0, 1, 0, 4'h0, 0);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 0);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 0);
    add(1, 3'd1, 4'h6, 0, 1, 0, 4'h0, 0);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 0);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 0);
    add(1, 3'd2, 4'h3, 0, 1, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++) add(1, 3'd0, 4'h9, 0, 0, 1, 4'hF, 0);
    add(0, 3'd0, 4'h0, 1, 0, 1, 4'hF, 0);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 0);
    // skipped index: error, no output, then a clean set
    add(1, 3'd0, 4'h5, 0, 1, 0, 4'h0, 0);
    add(1, 3'd2, 4'h9, 0, 1, 0, 4'h0, 0);
    add(0, 3'd0, 4'h0, 1, 1, 0, 4'h0, 1);
    add(1, 3'd0, 4'h1, 0, 1, 0, 4'h0, 0);
    add(1, 3'd1, 4'h2, 0, 1, 0, 4'h0, 0);
    add(1, 3'd2, 4'h4, 0, 1, 0, 4'h0, 0);
    add(0, 3'd0, 4'h0, 1, 0, 1, 4'h7, 0);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 0);
    // repeated idx 0 restarts collection
    add(1, 3'd0, 4'h3, 0, 1, 0, 4'h0, 0);
    add(1, 3'd0, 4'hC, 0, 1, 0, 4'h0, 0);
    add(1, 3'd1, 4'h0, 0, 1, 0, 4'h0, 1);
    add(1, 3'd2, 4'h0, 0, 1, 0, 4'h0, 0);
    add(0, 3'd0, 4'h0, 1, 0, 1, 4'hC, 0);
    add(0, 3'd0, 4'h0, 0, 1, 0, 4'h0, 0);

    // reset state
    repeat (3) step();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    check("rst_err",     32'(err),     32'd0);
    rst_n = 1'b1;
    check("post_rst_s_ready", 32'(s_ready), 32'd0);
    step();
    check("post_rst1_s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
      check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      check($sformatf("v%0d_m_data", i),  32'(m_data),  32'(vecs[i].e_md));
      check($sformatf("v%0d_err", i),     32'(err),     32'(vecs[i].e_err));
      drive(vecs[i].v, vecs[i].idx, vecs[i].sh, vecs[i].mr);
      step();
    end
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    step();

    // async reset mid-collection, then a fresh set
    drive(1'b1, 3'd0, 4'h3, 1'b0); step();
    drive(1'b1, 3'd1, 4'h5, 1'b0); step();
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc_s_ready", 32'(s_ready), 32'd0);
    check("arst_acc_m_valid", 32'(m_valid), 32'd0);
    check("arst_acc_err",     32'(err),     32'd0);
    step();
    rst_n = 1'b1;
    check("arst_rel_s_ready", 32'(s_ready), 32'd0);
    step();
    check("arst_rel1_s_ready", 32'(s_ready), 32'd1);
    drive(1'b1, 3'd0, 4'hF, 1'b0); step();
    drive(1'b1, 3'd1, 4'hF, 1'b0); step();
    drive(1'b1, 3'd2, 4'h1, 1'b0); step();
    drive(1'b0, 3'd0, 4'h0, 1'b1);
    check("fresh_m_valid", 32'(m_valid), 32'd1);
    check("fresh_m_data",  32'(m_data),  32'h1);
    step();
    check("fresh_done_m_valid", 32'(m_valid), 32'd0);
    drive(1'b0, 3'd0, 4'h0, 1'b0);

    // async reset while presenting a result
    drive(1'b1, 3'd0, 4'h2, 1'b0); step();
    drive(1'b1, 3'd1, 4'h4, 1'b0); step();
    drive(1'b1, 3'd2, 4'h8, 1'b0); step();
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    check("out_m_data", 32'(m_data), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_m_valid", 32'(m_valid), 32'd0);
    check("arst_out_m_data",  32'(m_data),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    // async reset during an err pulse
    drive(1'b1, 3'd2, 4'h1, 1'b0); step();
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    check("err_pulse", 32'(err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // random legal traffic with scoreboard
    mon_en = 1'b1;
    for (int s = 0; s < 20; s++) begin
      exp_x = 4'h0;
      for (int i = 0; i < 3; i++) begin
        repeat ($urandom_range(0, 2)) begin
          drive(1'b0, 3'd0, 4'h0, 1'b0);
          step();
        end
        check("rnd_s_ready", 32'(s_ready), 32'd1);
        sh = 4'($urandom_range(0, 15));
        exp_x = exp_x ^ sh;
        drive(1'b1, 3'(i), sh, 1'b0);
        step();
      end
      drive(1'b0, 3'd0, 4'h0, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        check("rnd_hold_m_data", 32'(m_data), 32'(exp_x));
        step();
      end
      check("rnd_m_valid", 32'(m_valid), 32'd1);
      check("rnd_m_data",  32'(m_data),  32'(exp_x));
      check("rnd_err",     32'(err),     32'd0);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("rnd_after_m_valid", 32'(m_valid), 32'd0);
    end
    mon_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
